// File: rtl/std_async_fifo_pkg.sv
// Shared definitions for the dual-clock FIFO write/read pointer controllers.
// Width derivation and the pointer compare used for full (write side) and empty (read side).
package std_async_fifo_pkg;

  function automatic int unsigned addr_width_f(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned ptr_width_f(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Full when the next write gray equals the read gray with its two MSBs inverted;
  // for a 2-bit pointer that is simply the inverted read gray.
  function automatic logic full_match(input logic [31:0] wr_gray_next,
                                      input logic [31:0] rd_gray,
                                      input int unsigned width);
    logic [31:0] mask;
    logic [31:0] flip;
    mask = (32'd1 << width) - 32'd1;
    flip = 32'd3 << (width - 2);
    return ((wr_gray_next ^ rd_gray ^ flip) & mask) == '0;
  endfunction

endpackage

// File: rtl/std_gray_counter.sv
// Binary/gray pointer counter with registered gray output and next-value outputs.
module std_gray_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] gray_next,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] bin_next
);

  always_comb begin
    bin_next  = bin + WIDTH'(inc);
    gray_next = bin_next ^ (bin_next >> 1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin  <= '0;
      gray <= '0;
    end else begin
      bin  <= bin_next;
      gray <= gray_next;
    end
  end

endmodule

// File: rtl/std_gray_decoder.sv
// Combinational gray-to-binary decoder.
module std_gray_decoder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/std_gray_ptr_sync.sv
// Plain flop chain for bringing a gray pointer across a clock boundary.
module std_gray_ptr_sync #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stages [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= d;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/std_async_fifo_wr_ctrl.sv
// Write-side pointer/flag controller of a dual-clock FIFO (write clock domain only).
module std_async_fifo_wr_ctrl
  import std_async_fifo_pkg::*;
#(
  parameter int unsigned DEPTH                 = 8,
  parameter int unsigned SYNC_STAGES           = 2,
  parameter int unsigned ALMOST_FULL_THRESHOLD = DEPTH - 1,
  localparam int unsigned ADDR_WIDTH           = addr_width_f(DEPTH),
  localparam int unsigned PTR_WIDTH            = ptr_width_f(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [PTR_WIDTH-1:0]  i_rd_ptr_gray,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [PTR_WIDTH-1:0]  o_wr_ptr_gray,
  output logic                  o_full,
  output logic                  o_almost_full,
  output logic [PTR_WIDTH-1:0]  o_word_count,
  output logic                  o_overflow
);

  logic                 push_ok;
  logic [PTR_WIDTH-1:0] wr_gray;
  logic [PTR_WIDTH-1:0] wr_gray_next;
  logic [PTR_WIDTH-1:0] wr_bin;
  logic [PTR_WIDTH-1:0] wr_bin_next;
  logic [PTR_WIDTH-1:0] rd_sync_gray;
  logic [PTR_WIDTH-1:0] rd_sync_bin;
  logic [PTR_WIDTH-1:0] count_next;

  assign push_ok = i_push & ~o_full;
  assign o_wr_en = push_ok;

  std_gray_counter #(.WIDTH(PTR_WIDTH)) u_wr_cnt (
    .clk       (i_clk),
    .rst_n     (i_rst),
    .inc       (push_ok),
    .gray      (wr_gray),
    .gray_next (wr_gray_next),
    .bin       (wr_bin),
    .bin_next  (wr_bin_next)
  );

  std_gray_ptr_sync #(.WIDTH(PTR_WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
    .clk   (i_clk),
    .rst_n (i_rst),
    .d     (i_rd_ptr_gray),
    .q     (rd_sync_gray)
  );

  std_gray_decoder #(.WIDTH(PTR_WIDTH)) u_rd_dec (
    .gray (rd_sync_gray),
    .bin  (rd_sync_bin)
  );

  assign o_wr_ptr_gray = wr_gray;
  assign o_wr_addr     = wr_bin[ADDR_WIDTH-1:0];
  // Modulo-2^PTR_WIDTH difference; the wrap bit keeps it right across pointer wrap.
  assign count_next    = wr_bin_next - rd_sync_bin;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_full        <= 1'b0;
      o_almost_full <= 1'b0;
      o_word_count  <= '0;
      o_overflow    <= 1'b0;
    end else begin
      o_full        <= full_match(32'(wr_gray_next), 32'(rd_sync_gray), PTR_WIDTH);
      o_almost_full <= count_next >= PTR_WIDTH'(ALMOST_FULL_THRESHOLD);
      o_word_count  <= count_next;
      o_overflow    <= i_push & o_full;
    end
  end

endmodule

// File: tb/tb_std_async_fifo_wr_ctrl.sv
// Directed self-checking bench for std_async_fifo_wr_ctrl with DEPTH=4, SYNC_STAGES=2.
module tb_std_async_fifo_wr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       push;
  logic [2:0] rd_ptr_gray;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [2:0] wr_ptr_gray;
  logic       full;
  logic       almost_full;
  logic [2:0] word_count;
  logic       overflow;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  std_async_fifo_wr_ctrl #(
    .DEPTH                 (4),
    .SYNC_STAGES           (2),
    .ALMOST_FULL_THRESHOLD (3)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_push        (push),
    .i_rd_ptr_gray (rd_ptr_gray),
    .o_wr_en       (wr_en),
    .o_wr_addr     (wr_addr),
    .o_wr_ptr_gray (wr_ptr_gray),
    .o_full        (full),
    .o_almost_full (almost_full),
    .o_word_count  (word_count),
    .o_overflow    (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [2:0] g, input logic [1:0] a,
                           input logic f, input logic af, input logic [2:0] c, input logic ov);
    chk({tag, ".gray"},  32'(wr_ptr_gray), 32'(g));
    chk({tag, ".addr"},  32'(wr_addr),     32'(a));
    chk({tag, ".full"},  32'(full),        32'(f));
    chk({tag, ".afull"}, 32'(almost_full), 32'(af));
    chk({tag, ".count"}, 32'(word_count),  32'(c));
    chk({tag, ".ovf"},   32'(overflow),    32'(ov));
  endtask

  function automatic logic [2:0] to_gray(input int unsigned b);
    logic [2:0] v;
    v = 3'(b);
    return v ^ (v >> 1);
  endfunction

  initial begin
    rst = 1'b0; push = 1'b1; rd_ptr_gray = 3'b000;
    #2;

    // Reset held for two edges with push asserted
    step(); chk_state("rst1", 3'b000, 2'd0, 0, 0, 3'd0, 0);
    step(); chk_state("rst2", 3'b000, 2'd0, 0, 0, 3'd0, 0);
    push = 1'b0; rst = 1'b1; #1;
    chk("rel.wr_en", 32'(wr_en), 32'd0);
    step(); chk_state("idle", 3'b000, 2'd0, 0, 0, 3'd0, 0);

    // Fill with four pushes
    push = 1'b1; #1;
    chk("fill.wr_en", 32'(wr_en), 32'd1);
    step(); chk_state("fill1", 3'b001, 2'd1, 0, 0, 3'd1, 0);
    step(); chk_state("fill2", 3'b011, 2'd2, 0, 0, 3'd2, 0);
    step(); chk_state("fill3", 3'b010, 2'd3, 0, 1, 3'd3, 0);
    step(); chk_state("fill4", 3'b110, 2'd0, 1, 1, 3'd4, 0);
    chk("full.wr_en", 32'(wr_en), 32'd0);

    // Overflow pulse on push while full
    step(); chk_state("ovf", 3'b110, 2'd0, 1, 1, 3'd4, 1);
    push = 1'b0;
    step(); chk_state("ovf_end", 3'b110, 2'd0, 1, 1, 3'd4, 0);

    // Read pointer advance seen after SYNC_STAGES+1 edges
    rd_ptr_gray = 3'b001;
    step(); chk("drain1.full", 32'(full), 32'd1);
    step(); chk("drain2.full", 32'(full), 32'd1);
    step(); chk_state("drain3", 3'b110, 2'd0, 0, 1, 3'd3, 0);

    // Refill to full, then push in the same cycle the read pointer advances
    push = 1'b1;
    step(); chk_state("refill", 3'b111, 2'd1, 1, 1, 3'd4, 0);
    rd_ptr_gray = 3'b011;
    step(); chk_state("simul", 3'b111, 2'd1, 1, 1, 3'd4, 1);
    push = 1'b0;
    step(); chk("lag1.full", 32'(full), 32'd1);
    step(); chk_state("lag2", 3'b111, 2'd1, 0, 1, 3'd3, 0);
    push = 1'b1; #1;
    chk("retry.wr_en", 32'(wr_en), 32'd1);
    step(); chk_state("retry", 3'b101, 2'd2, 1, 1, 3'd4, 0);

    // Wrap: reset, then stream with the reader consuming each word as it lands
    push = 1'b0; rst = 1'b0; rd_ptr_gray = 3'b000;
    step(); chk_state("rst3", 3'b000, 2'd0, 0, 0, 3'd0, 0);
    rst = 1'b1;
    for (int unsigned i = 1; i <= 20; i++) begin
      push = 1'b1; #1;
      chk($sformatf("wrap%0d.wr_en", i), 32'(wr_en), 32'd1);
      step();
      chk($sformatf("wrap%0d.addr", i),  32'(wr_addr),     32'(i % 4));
      chk($sformatf("wrap%0d.gray", i),  32'(wr_ptr_gray), 32'(to_gray(i % 8)));
      chk($sformatf("wrap%0d.count", i), 32'(word_count),  32'((i < 3) ? i : 3));
      chk($sformatf("wrap%0d.full", i),  32'(full),        32'd0);
      rd_ptr_gray = to_gray(i % 8);
    end
    push = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
